dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, default 12, data-memory address width.
REQ-002 Parameter: DW, default 12, data-memory word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 (core) access request; level, held until done0.
REQ-006 we0  input  1  requester 0 access type: 1 write, 0 read.
REQ-007 addr0  input  AW  requester 0 word address.
REQ-008 wdata0  input  DW  requester 0 write data.
REQ-009 req1, we1, addr1, wdata1  input  1/1/AW/DW  requester 1 (loader/DMA), same meaning as requester 0.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-011 rdata  output  DW  read data; valid only in the cycle doneN pulses for a read.
REQ-012 busy  output  1  high while an access is in flight (state not IDLE).
REQ-013 gnt_id  output  1  index of the current or last granted requester.
REQ-014 mem_write_en  output  1  to data memory write_en.
REQ-015 mem_addr  output  AW  to data memory addr.
REQ-016 mem_datain  output  DW  to data memory datain.
REQ-017 mem_dataout  input  DW  from data memory dataout (registered, one-cycle read latency).

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; all outputs registered.
REQ-019 IDLE: no request -> stay IDLE; any request -> latch winner's we/addr/wdata onto mem_* outputs, set gnt_id, go ACCESS next cycle.
REQ-020 Arbitration: one requester -> it wins; both -> the one not equal to last-grant pointer wins (round-robin); pointer updates on grant.
REQ-021 ACCESS, write: mem_write_en high for exactly this one cycle; next cycle done[gnt_id]=1, mem_write_en=0, state IDLE.
REQ-022 ACCESS, read: mem_write_en stays 0; go RESP.
REQ-023 RESP: rdata <= mem_dataout; next cycle done[gnt_id]=1 with rdata valid, state IDLE.
REQ-024 Latency from request sampled in IDLE to done: write 2 cycles, read 3 cycles; at most one access in flight.
REQ-025 done0 and done1 never high in the same cycle; each high at most one cycle per grant.
REQ-026 Requester inputs are ignored outside IDLE; a request dropped mid-access does not abort it; done still pulses.
REQ-027 Requester still high in the IDLE cycle its done pulses is treated as a new request (back-to-back allowed, subject to REQ-020).
REQ-028 mem_addr/mem_datain hold their last value in IDLE; mem_write_en is 1 only in ACCESS for writes.
REQ-029 No address checking; full AW range including 4095 passed through unchanged.

Reset
REQ-030 rst_n low, asynchronous: state IDLE; mem_write_en, done0, done1, busy 0; mem_addr, mem_datain, rdata 0; gnt_id 0; round-robin pointer 1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-access aborts it: no done pulse, mem_write_en drops immediately; any write not yet clocked into memory is lost.
REQ-032 After rst_n rises, first grant no earlier than the first rising edge with rst_n high.

Verification
REQ-033 Single write: req0=1, we0=1, addr0=4094, wdata0=12'd7 -> mem_write_en high one cycle with mem_addr=4094, mem_datain=7; done0 two cycles after sample; busy 1 for those cycles.
REQ-034 Single read: req1=1, we1=0, addr1=4 with memory holding 21 -> done1 three cycles after sample, rdata=21 that cycle, done0 stays 0.
REQ-035 Tie after reset: req0 and req1 both high (reads to 5 and 68) -> requester 0 served first (rdata=22), then requester 1 (rdata=23), no idle gap beyond FSM.
REQ-036 Sustained contention: both requesters hold req for 6 grants -> grants alternate 0,1,0,1,0,1; gnt_id matches.
REQ-037 Mid-access reset: rst_n low during ACCESS of write to addr 2 -> mem_write_en 0 immediately, no done, all outputs at reset values; memory word 2 unchanged.
REQ-038 Dropped request: req0 deasserted in ACCESS of a read of addr 69 -> done0 still pulses with rdata=24.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory with a
// registered (one-cycle latency) read port. One access in flight at a time;
// ties are broken round-robin against the last granted requester.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0      requester 0 (core): level request held until done0
//   req1/we1/addr1/wdata1      requester 1 (loader/DMA): same meaning
//   done0, done1               one-cycle completion pulse to the owner
//   rdata                      read data, valid in the done cycle of a read
//   busy                       high while an access is in flight
//   gnt_id                     current or last granted requester
//   mem_write_en/addr/datain   to data memory
//   mem_dataout                from data memory (registered)
//
// state  | meaning
// IDLE   | waiting for a request; done pulses in this state
// ACCESS | memory addressed; write strobe high for writes
// RESP   | read data arriving on mem_dataout, captured into rdata
module dmem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          gnt_id,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic          mem_write_en_q, mem_write_en_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_datain_q, mem_datain_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          busy_q, busy_d;
    logic          gnt_id_q, gnt_id_d;
    logic          rr_q, rr_d;
    logic          win;

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        mem_write_en_d = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_datain_d   = mem_datain_q;
        rdata_d        = rdata_q;
        done0_d        = 1'b0;
        done1_d        = 1'b0;
        busy_d         = busy_q;
        gnt_id_d       = gnt_id_q;
        rr_d           = rr_q;
        win            = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not granted last wins.
                    win            = (req0 && req1) ? ~rr_q : req1;
                    gnt_id_d       = win;
                    rr_d           = win;
                    we_d           = win ? we1 : we0;
                    mem_addr_d     = win ? addr1 : addr0;
                    mem_datain_d   = win ? wdata1 : wdata0;
                    mem_write_en_d = win ? we1 : we0;
                    busy_d         = 1'b1;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    done0_d = ~gnt_id_q;
                    done1_d = gnt_id_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d = mem_dataout;
                done0_d = ~gnt_id_q;
                done1_d = gnt_id_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_datain_q   <= '0;
            rdata_q        <= '0;
            done0_q        <= 1'b0;
            done1_q        <= 1'b0;
            busy_q         <= 1'b0;
            gnt_id_q       <= 1'b0;
            rr_q           <= 1'b1;     // requester 0 wins the first tie
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            mem_write_en_q <= mem_write_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_datain_q   <= mem_datain_d;
            rdata_q        <= rdata_d;
            done0_q        <= done0_d;
            done1_q        <= done1_d;
            busy_q         <= busy_d;
            gnt_id_q       <= gnt_id_d;
            rr_q           <= rr_d;
        end
    end

    assign done0        = done0_q;
    assign done1        = done1_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign gnt_id       = gnt_id_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_datain   = mem_datain_q;

endmodule
